// File: rtl/crc22_chk_pkg.sv
// Shared definitions for the DMB crc22 generator/checker pair:
// word-step CRC function, CRC word marker and checker state encoding.
package crc22_chk_pkg;

  localparam logic [3:0] CRC_MARK = 4'hE;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // One 16-bit word through x^22+x+1, LSB first; bits 22/23 are the
  // parities of the two 11-bit halves that travel in the CRC words.
  function automatic logic [23:0] crc22_next(input logic [15:0] din,
                                             input logic [21:0] fb);
    logic [21:0] c;
    logic        t;
    c = fb;
    for (int k = 0; k < 16; k++) begin
      t = c[0] ^ din[k];
      c = {t, c[21] ^ t, c[20:1]};
    end
    return {^c[21:11], ^c[10:0], c};
  endfunction

endpackage

// File: rtl/crc22_step.sv
// Combinational single-word crc22 step; zero latency, no flow control.
module crc22_step
  import crc22_chk_pkg::*;
(
  input  logic [15:0] i_din,
  input  logic [21:0] i_fb,
  output logic [23:0] o_crc
);

  assign o_crc = crc22_next(i_din, i_fb);

endmodule

// File: rtl/crc22_chk.sv
// Receive-side crc22 frame checker: result registered one cycle after EOF
// (or aborting SOF); accepts a word every cycle, never backpressures.
module crc22_chk
  import crc22_chk_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DIN,
  input  logic        DV,
  input  logic        SOF,
  input  logic        EOF,
  output logic        DONE,
  output logic        CRC_OK,
  output logic        CRC_ERR,
  output logic        FMT_ERR,
  output logic [23:0] CALC_CRC,
  output logic [23:0] RX_CRC,
  output logic [15:0] FRM_CNT,
  output logic [15:0] ERR_CNT
);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [21:0] r_crc;
  logic [15:0] r_p0;
  logic [15:0] r_p1;
  logic        r_done;
  logic        r_ok;
  logic        r_cerr;
  logic        r_fmt;
  logic [23:0] r_calc;
  logic [23:0] r_rx;
  logic [15:0] r_frm;
  logic [15:0] r_err;

  logic [23:0] w_step;
  logic [23:0] w_rx;
  logic        w_eof;
  logic        w_fin;
  logic        w_ok;
  logic        w_cerr;
  logic        w_fmt;

  // Accumulate and final step both fold the word two behind the newest.
  crc22_step u_step (
    .i_din (r_p1),
    .i_fb  (r_crc),
    .o_crc (w_step)
  );

  assign w_rx  = {DIN[11], r_p0[11], DIN[10:0], r_p0[10:0]};
  assign w_eof = DV && EOF && !SOF && (r_state == ST_FRAME);

  always_comb begin
    w_fin  = 1'b0;
    w_ok   = 1'b0;
    w_cerr = 1'b0;
    w_fmt  = 1'b0;
    if (DV && SOF && (EOF || r_state == ST_FRAME)) begin
      w_fin = 1'b1;
      w_fmt = 1'b1;
    end else if (w_eof) begin
      w_fin = 1'b1;
      if (r_cnt != 2'd2 || r_p0[15:12] != CRC_MARK || DIN[15:12] != CRC_MARK)
        w_fmt = 1'b1;
      else if (w_step == w_rx)
        w_ok = 1'b1;
      else
        w_cerr = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_crc   <= '0;
      r_p0    <= '0;
      r_p1    <= '0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
      r_cerr  <= 1'b0;
      r_fmt   <= 1'b0;
      r_calc  <= '0;
      r_rx    <= '0;
      r_frm   <= '0;
      r_err   <= '0;
    end else begin
      r_done <= w_fin;
      r_ok   <= w_ok;
      r_cerr <= w_cerr;
      r_fmt  <= w_fmt;
      if (w_fin) begin
        r_frm <= r_frm + 16'd1;
        if (!w_ok && r_err != 16'hFFFF)
          r_err <= r_err + 16'd1;
      end
      if (w_eof && r_cnt == 2'd2) begin
        r_calc <= w_step;
        r_rx   <= w_rx;
      end
      if (DV) begin
        if (SOF && !EOF) begin
          r_state <= ST_FRAME;
          r_crc   <= '0;
          r_p0    <= DIN;
          r_cnt   <= 2'd1;
        end else if (SOF || w_eof) begin
          r_state <= ST_IDLE;
          r_cnt   <= 2'd0;
        end else if (r_state == ST_FRAME) begin
          if (r_cnt == 2'd2)
            r_crc <= w_step[21:0];
          r_p1 <= r_p0;
          r_p0 <= DIN;
          if (r_cnt != 2'd2)
            r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

  assign DONE     = r_done;
  assign CRC_OK   = r_ok;
  assign CRC_ERR  = r_cerr;
  assign FMT_ERR  = r_fmt;
  assign CALC_CRC = r_calc;
  assign RX_CRC   = r_rx;
  assign FRM_CNT  = r_frm;
  assign ERR_CNT  = r_err;

endmodule

// File: doc/crc22_chk.md
# crc22_chk

Receive-side CRC checker for the 16-bit DMB frame stream, the counterpart of the crc22 generator. Consumes words with start- and end-of-frame markers and computes the 22+2-bit frame CRC over every data word. At end of frame it compares the result against the CRC carried in the two trailing CRC words and reports pass/fail. It sits on the readback/monitor path after frame reassembly, ahead of the error-status registers.

## Interface
- No parameters.
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- DIN  in  16  frame word
- DV  in  1  DIN valid; all other inputs are ignored when low
- SOF  in  1  DIN is the first word of a frame (qualified by DV)
- EOF  in  1  DIN is the last word of the frame, i.e. CRC word 1 (qualified by DV)
- DONE  out  1  one-cycle pulse; frame result valid
- CRC_OK  out  1  valid with DONE; CRC matched and format was good
- CRC_ERR  out  1  valid with DONE; format was good and the CRC mismatched
- FMT_ERR  out  1  valid with DONE; frame was truncated, aborted, too short, or a CRC-word marker was bad
- CALC_CRC  out  24  computed CRC of the last frame; held until the next DONE
- RX_CRC  out  24  received CRC of the last frame; held until the next DONE
- FRM_CNT  out  16  frames completed; wraps
- ERR_CNT  out  16  frames with CRC_ERR or FMT_ERR; saturates at 16'hFFFF

## Operation
- **Frame layout:** data words D0..Dn-1 (n ≥ 1), then CRCW0 and CRCW1.
  - CRCW0 = {4'hE, crc[22], crc[10:0]}
  - CRCW1 = {4'hE, crc[23], crc[21:11]}
  - Minimum legal frame is 3 words.
- **CRC step:** identical to the generator. Register reset value is 0. Per word, crc[4:0] = fb[20:16], crc[21:5] per the crc22 polynomial, crc[22] = ^crc[10:0], crc[23] = ^crc[21:11]. Feedback uses only bits [21:0].
- **Two-word delay line:** P0 is the newest word, P1 the one before it. CNT (0..2) counts valid entries.
  - On each non-SOF DV word in FRAME: if CNT == 2, apply crc <= step(crc, P1). Then P1 <= P0, P0 <= DIN, and CNT saturates at 2.
  - Net effect: the last two words of the frame are never folded into the CRC.
- **States:** IDLE and FRAME.
  - IDLE + DV&SOF&!EOF: go to FRAME. crc <= 0, P0 <= DIN, CNT <= 1.
  - IDLE + DV without SOF: the word is dropped; no status change.
  - FRAME + DV&EOF (no SOF):
    - If CNT == 2: CALC_CRC <= step(crc, P1) and RX_CRC <= {DIN[11], P0[11], DIN[10:0], P0[10:0]}.
    - FMT_ERR if CNT < 2, or P0[15:12] != 4'hE, or DIN[15:12] != 4'hE.
    - Otherwise CRC_OK if CALC_CRC == RX_CRC, else CRC_ERR.
    - Go to IDLE.
  - FRAME + DV&SOF: the old frame is aborted (DONE with FMT_ERR) and the new frame starts exactly as from IDLE, in the same cycle.
  - DV&SOF&EOF in either state: single-word frame. DONE with FMT_ERR; end in IDLE.
- On every DONE, FRM_CNT increments. ERR_CNT increments unless the result is CRC_OK.
- Exactly one of CRC_OK/CRC_ERR/FMT_ERR is high with DONE; all three are low otherwise.
- RST: state IDLE, CNT 0, crc 0, and every output 0 (DONE, flags, CALC_CRC, RX_CRC, FRM_CNT, ERR_CNT). A frame in progress when RST asserts is discarded with no DONE.

## Timing
- DONE and its flags, CALC_CRC and RX_CRC are registered. They appear the cycle after the EOF word (or the aborting SOF word) is sampled: latency 1.
- Counters update on the same edge as DONE.
- The block accepts one word per cycle indefinitely with no backpressure. Gaps (DV low) are allowed anywhere and hold all state.
- Back-to-back frames need no idle cycle: an EOF word may be followed directly by a SOF word.

## Structure
- Shared package:
  - crc22 step function (16-bit din, 22-bit fb → 24-bit crc), also usable by the generator
  - CRC word marker constant 4'hE
  - state enum
- One natural sub-module: crc22_step, a purely combinational wrapper of the package function, instantiated once for the accumulate/final step.

## Test plan
- SOF 16'h0000, 16'hE000, EOF 16'hE000 → DONE, CRC_OK, CALC_CRC = RX_CRC = 24'h000000, FRM_CNT = 1, ERR_CNT = 0.
- SOF 16'h0001, 16'hE060, EOF 16'hE000 → CRC_OK, CALC_CRC = 24'h000060.
- SOF 16'h0001, 16'hE061, EOF 16'hE000 → CRC_ERR, RX_CRC = 24'h000061, ERR_CNT = 1.
- SOF 16'h0001, 16'hE060, EOF 16'hF000 → FMT_ERR.
- Two-word frame: SOF 16'hE000 then EOF 16'hE000 → FMT_ERR.
- SOF then a second SOF mid-frame → FMT_ERR DONE for the first frame. A following valid frame then yields CRC_OK.
- DV gaps inserted in a valid frame → same result as with no gaps.
- RST asserted mid-frame → no DONE; all outputs return to 0.
